// File: rtl/serdes_pkg.sv
// Shared types and constants for the SerDes link controller.
package serdes_pkg;

    // Link controller states; the encoding is visible on o_State.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_TRAIN   = 2'd1,
        ST_LINK_UP = 2'd2,
        ST_RECOVER = 2'd3
    } link_state_t;

    // K28.5 comma character used for training and idle fill.
    localparam logic [7:0] K28_5_BYTE = 8'hBC;
    // Ceiling of the retrain counter.
    localparam logic [7:0] RETRY_MAX  = 8'hFF;

    // Increment that sticks at RETRY_MAX.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == RETRY_MAX) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/serdes_link_ctrl_if.sv
// Byte-level signals between the link controller, the user side and the
// SerDes datapath (serializer byte input, decoder status, deserializer FIFO).
interface serdes_link_ctrl_if;
    logic [7:0] i_Tx_Data;
    logic       i_Tx_Valid;
    logic       o_Tx_Ready;
    logic [7:0] o_Ser_Data;
    logic       o_Ser_K;
    logic       i_Rx_Valid;
    logic       i_Rx_Comma;
    logic       i_Rx_Code_Err;
    logic       i_Fifo_Full;
    logic       i_Fifo_Empty;
    logic       o_W_En;
    logic       o_R_En;

    // Controller side.
    modport master (
        input  i_Tx_Data, i_Tx_Valid, i_Rx_Valid, i_Rx_Comma, i_Rx_Code_Err,
               i_Fifo_Full, i_Fifo_Empty,
        output o_Tx_Ready, o_Ser_Data, o_Ser_K, o_W_En, o_R_En
    );

    // User / datapath side.
    modport slave (
        output i_Tx_Data, i_Tx_Valid, i_Rx_Valid, i_Rx_Comma, i_Rx_Code_Err,
               i_Fifo_Full, i_Fifo_Empty,
        input  o_Tx_Ready, o_Ser_Data, o_Ser_K, o_W_En, o_R_En
    );
endinterface

// File: rtl/serdes_err_mon.sv
// Receive code-error monitor: counts decoder errors inside a free-running
// fixed-length window and flags when the count reaches the limit.
module serdes_err_mon
    import serdes_pkg::*;
#(
    parameter int ERR_WINDOW = 256,
    parameter int ERR_MAX    = 4
) (
    input  logic clk,
    input  logic srst,
    input  logic clr,          // holds both counters at zero (link not up)
    input  logic rx_valid,
    input  logic rx_code_err,
    output logic err_trip
);
    localparam int WIN_W = $clog2(ERR_WINDOW) + 1;
    localparam int ERR_W = $clog2(ERR_MAX) + 1;

    logic [WIN_W-1:0] win_q, win_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic             err_now;
    logic             wrap;

    // Window/error next-state; an error on the wrap cycle opens the new window.
    always_comb begin
        err_now  = rx_valid & rx_code_err;
        wrap     = (win_q == WIN_W'(ERR_WINDOW - 1));
        win_d    = wrap ? '0 : win_q + WIN_W'(1);
        err_d    = wrap ? '0 : err_q;
        if (err_now) begin
            err_d = err_d + ERR_W'(1);
        end
        err_trip = 1'b0;
        if (clr) begin
            win_d = '0;
            err_d = '0;
        end else if (err_d >= ERR_W'(ERR_MAX)) begin
            err_trip = 1'b1;
        end
    end

    // Counter registers.
    always_ff @(posedge clk) begin
        if (srst) begin
            win_q <= '0;
            err_q <= '0;
        end else begin
            win_q <= win_d;
            err_q <= err_d;
        end
    end

endmodule

// File: rtl/serdes_link_ctrl.sv
// Link bring-up and run-time controller: comma training, lock detection,
// user byte muxing onto the serializer, FIFO enable gating and retrain on
// training timeout or excess receive code errors.
module serdes_link_ctrl
    import serdes_pkg::*;
#(
    parameter int RST_HOLD      = 16,
    parameter int LOCK_CNT      = 8,
    parameter int TRAIN_TIMEOUT = 1024,
    parameter int ERR_WINDOW    = 256,
    parameter int ERR_MAX       = 4
) (
    input  logic                i_Clk,
    input  logic                i_Rst,
    serdes_link_ctrl_if.master  lnk,
    output logic                o_Link_Up,
    output logic [1:0]          o_State,
    output logic [7:0]          o_Retry_Cnt
);
    localparam int HOLD_W = $clog2(RST_HOLD) + 1;
    localparam int LOCK_W = $clog2(LOCK_CNT) + 1;
    localparam int TO_W   = $clog2(TRAIN_TIMEOUT) + 1;

    link_state_t       state_q, state_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [LOCK_W-1:0] lock_q, lock_d;
    logic [TO_W-1:0]   to_q, to_d;
    logic [7:0]        retry_q, retry_d;
    logic [7:0]        ser_data_q, ser_data_d;
    logic              ser_k_q, ser_k_d;
    logic              tx_ready_q, tx_ready_d;
    logic              w_en_q, w_en_d;
    logic              r_en_q, r_en_d;
    logic              link_up_q, link_up_d;
    logic              rx_good;
    logic              err_trip;

    // Error monitor only runs while the link is up.
    serdes_err_mon #(
        .ERR_WINDOW (ERR_WINDOW),
        .ERR_MAX    (ERR_MAX)
    ) u_err_mon (
        .clk         (i_Clk),
        .srst        (i_Rst),
        .clr         (state_q != ST_LINK_UP),
        .rx_valid    (lnk.i_Rx_Valid),
        .rx_code_err (lnk.i_Rx_Code_Err),
        .err_trip    (err_trip)
    );

    // Next state, per-state counters and registered output values.
    always_comb begin
        state_d = state_q;
        hold_d  = '0;
        lock_d  = '0;
        to_d    = '0;
        retry_d = retry_q;
        rx_good = lnk.i_Rx_Valid & lnk.i_Rx_Comma & ~lnk.i_Rx_Code_Err;

        case (state_q)
            ST_IDLE: begin
                hold_d = hold_q + HOLD_W'(1);
                if (hold_q == HOLD_W'(RST_HOLD - 1)) begin
                    hold_d  = '0;
                    state_d = ST_TRAIN;
                end
            end
            ST_TRAIN: begin
                lock_d = lock_q;
                if (lnk.i_Rx_Valid) begin
                    lock_d = rx_good ? lock_q + LOCK_W'(1) : '0;
                end
                to_d = to_q + TO_W'(1);
                // Lock takes priority over a timeout in the same cycle.
                if (lock_d == LOCK_W'(LOCK_CNT)) begin
                    lock_d  = '0;
                    to_d    = '0;
                    state_d = ST_LINK_UP;
                end else if (to_q == TO_W'(TRAIN_TIMEOUT - 1)) begin
                    lock_d  = '0;
                    to_d    = '0;
                    state_d = ST_RECOVER;
                end
            end
            ST_LINK_UP: begin
                if (err_trip) begin
                    state_d = ST_RECOVER;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // RECOVER lasts exactly one cycle, so this counts each retrain once.
        if (state_d == ST_RECOVER) begin
            retry_d = sat_inc8(retry_q);
        end

        // Enables follow the next state so they drop together on exit.
        link_up_d  = (state_d == ST_LINK_UP);
        tx_ready_d = (state_d == ST_LINK_UP);
        w_en_d     = (state_d == ST_LINK_UP) & ~lnk.i_Fifo_Full;
        r_en_d     = (state_d == ST_LINK_UP) & ~lnk.i_Fifo_Empty;

        // A byte is taken only while o_Tx_Ready is high; otherwise idle comma.
        if ((state_q == ST_LINK_UP) && lnk.i_Tx_Valid) begin
            ser_data_d = lnk.i_Tx_Data;
            ser_k_d    = 1'b0;
        end else begin
            ser_data_d = K28_5_BYTE;
            ser_k_d    = 1'b1;
        end
    end

    // State, counter and output registers.
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            state_q    <= ST_IDLE;
            hold_q     <= '0;
            lock_q     <= '0;
            to_q       <= '0;
            retry_q    <= '0;
            ser_data_q <= K28_5_BYTE;
            ser_k_q    <= 1'b1;
            tx_ready_q <= 1'b0;
            w_en_q     <= 1'b0;
            r_en_q     <= 1'b0;
            link_up_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            hold_q     <= hold_d;
            lock_q     <= lock_d;
            to_q       <= to_d;
            retry_q    <= retry_d;
            ser_data_q <= ser_data_d;
            ser_k_q    <= ser_k_d;
            tx_ready_q <= tx_ready_d;
            w_en_q     <= w_en_d;
            r_en_q     <= r_en_d;
            link_up_q  <= link_up_d;
        end
    end

    assign lnk.o_Tx_Ready = tx_ready_q;
    assign lnk.o_Ser_Data = ser_data_q;
    assign lnk.o_Ser_K    = ser_k_q;
    assign lnk.o_W_En     = w_en_q;
    assign lnk.o_R_En     = r_en_q;
    assign o_Link_Up      = link_up_q;
    assign o_State        = state_q;
    assign o_Retry_Cnt    = retry_q;

endmodule

// File: tb/tb_serdes_link_ctrl.sv
// Directed testbench for serdes_link_ctrl. Training timeout is shortened so
// the 300-retrain saturation scenario stays short; other parameters default.
module tb_serdes_link_ctrl;
    localparam int RST_HOLD      = 16;
    localparam int LOCK_CNT      = 8;
    localparam int TRAIN_TIMEOUT = 64;
    localparam int ERR_WINDOW    = 256;
    localparam int ERR_MAX       = 4;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_TRAIN = 2'd1;
    localparam logic [1:0] S_UP = 2'd2;
    localparam logic [1:0] S_REC = 2'd3;

    logic       clk;
    logic       rst;
    logic       link_up;
    logic [1:0] state;
    logic [7:0] retry;
    int         total;
    int         bad;

    serdes_link_ctrl_if lnk ();

    serdes_link_ctrl #(
        .RST_HOLD      (RST_HOLD),
        .LOCK_CNT      (LOCK_CNT),
        .TRAIN_TIMEOUT (TRAIN_TIMEOUT),
        .ERR_WINDOW    (ERR_WINDOW),
        .ERR_MAX       (ERR_MAX)
    ) dut (
        .i_Clk       (clk),
        .i_Rst       (rst),
        .lnk         (lnk),
        .o_Link_Up   (link_up),
        .o_State     (state),
        .o_Retry_Cnt (retry)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive point and sample point: 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic send_commas(input int n);
        lnk.i_Rx_Valid = 1'b1; lnk.i_Rx_Comma = 1'b1; lnk.i_Rx_Code_Err = 1'b0;
        repeat (n) tick();
        lnk.i_Rx_Valid = 1'b0; lnk.i_Rx_Comma = 1'b0;
    endtask

    task automatic send_errors(input int n);
        lnk.i_Rx_Valid = 1'b1; lnk.i_Rx_Comma = 1'b0; lnk.i_Rx_Code_Err = 1'b1;
        repeat (n) tick();
        lnk.i_Rx_Valid = 1'b0; lnk.i_Rx_Code_Err = 1'b0;
    endtask

    // From the first IDLE cycle: hold, then lock with LOCK_CNT commas.
    task automatic bring_up();
        wait_cycles(RST_HOLD);
        send_commas(LOCK_CNT);
    endtask

    task automatic test_reset();
        lnk.i_Tx_Valid = 1'b1; lnk.i_Tx_Data = 8'hAA;
        lnk.i_Fifo_Full = 1'b0; lnk.i_Fifo_Empty = 1'b0;
        rst = 1'b1;
        tick();
        tick();
        total++; if (state !== S_IDLE) begin bad++; $display("FAIL reset_state got=%0d exp=%0d", state, S_IDLE); end
        total++; if (lnk.o_Ser_Data !== 8'hBC) begin bad++; $display("FAIL reset_ser_data got=%h exp=bc", lnk.o_Ser_Data); end
        total++; if (lnk.o_Ser_K !== 1'b1) begin bad++; $display("FAIL reset_ser_k got=%b exp=1", lnk.o_Ser_K); end
        total++; if (lnk.o_Tx_Ready !== 1'b0) begin bad++; $display("FAIL reset_tx_ready got=%b exp=0", lnk.o_Tx_Ready); end
        total++; if (lnk.o_W_En !== 1'b0) begin bad++; $display("FAIL reset_w_en got=%b exp=0", lnk.o_W_En); end
        total++; if (lnk.o_R_En !== 1'b0) begin bad++; $display("FAIL reset_r_en got=%b exp=0", lnk.o_R_En); end
        total++; if (link_up !== 1'b0) begin bad++; $display("FAIL reset_link_up got=%b exp=0", link_up); end
        total++; if (retry !== 8'd0) begin bad++; $display("FAIL reset_retry got=%0d exp=0", retry); end
        lnk.i_Tx_Valid = 1'b0; lnk.i_Tx_Data = 8'h00;
        lnk.i_Fifo_Full = 1'b0; lnk.i_Fifo_Empty = 1'b1;
        $display("test_reset done");
    endtask

    task automatic test_lock();
        do_reset();
        wait_cycles(RST_HOLD - 1);
        total++; if (state !== S_IDLE) begin bad++; $display("FAIL hold_last_idle got=%0d exp=%0d", state, S_IDLE); end
        tick();
        total++; if (state !== S_TRAIN) begin bad++; $display("FAIL enter_train got=%0d exp=%0d", state, S_TRAIN); end
        send_commas(LOCK_CNT - 1);
        total++; if (state !== S_TRAIN) begin bad++; $display("FAIL lock_minus1_state got=%0d exp=%0d", state, S_TRAIN); end
        total++; if (link_up !== 1'b0) begin bad++; $display("FAIL lock_minus1_link got=%b exp=0", link_up); end
        total++; if (lnk.o_Ser_Data !== 8'hBC || lnk.o_Ser_K !== 1'b1) begin bad++; $display("FAIL train_tx got=%h/%b exp=bc/1", lnk.o_Ser_Data, lnk.o_Ser_K); end
        send_commas(1);
        total++; if (link_up !== 1'b1) begin bad++; $display("FAIL lock_link_up got=%b exp=1", link_up); end
        total++; if (state !== S_UP) begin bad++; $display("FAIL lock_state got=%0d exp=%0d", state, S_UP); end
        $display("test_lock done");
    endtask

    task automatic test_lock_clear();
        do_reset();
        wait_cycles(RST_HOLD);
        for (int i = 0; i < 5; i++) begin
            send_commas(1);
            tick();
        end
        lnk.i_Rx_Valid = 1'b1; lnk.i_Rx_Comma = 1'b0;
        tick();
        lnk.i_Rx_Valid = 1'b0;
        send_commas(LOCK_CNT - 1);
        total++; if (state !== S_TRAIN) begin bad++; $display("FAIL lock_clear_early got=%0d exp=%0d", state, S_TRAIN); end
        send_commas(1);
        total++; if (state !== S_UP) begin bad++; $display("FAIL lock_clear_final got=%0d exp=%0d", state, S_UP); end
        $display("test_lock_clear done");
    endtask

    task automatic test_timeout();
        int exp_retry;
        do_reset();
        wait_cycles(RST_HOLD);
        wait_cycles(TRAIN_TIMEOUT - 1);
        total++; if (state !== S_TRAIN) begin bad++; $display("FAIL timeout_early got=%0d exp=%0d", state, S_TRAIN); end
        tick();
        total++; if (state !== S_REC) begin bad++; $display("FAIL timeout_recover got=%0d exp=%0d", state, S_REC); end
        total++; if (retry !== 8'd1) begin bad++; $display("FAIL timeout_retry got=%0d exp=1", retry); end
        tick();
        total++; if (state !== S_IDLE) begin bad++; $display("FAIL timeout_idle got=%0d exp=%0d", state, S_IDLE); end
        for (int n = 2; n <= 300; n++) begin
            wait_cycles(RST_HOLD + TRAIN_TIMEOUT);
            exp_retry = (n > 255) ? 255 : n;
            total++; if (state !== S_REC || retry !== 8'(exp_retry)) begin bad++; $display("FAIL retry_loop n=%0d got=%0d/%0d exp=%0d/%0d", n, state, retry, S_REC, exp_retry); end
            tick();
        end
        total++; if (retry !== 8'd255) begin bad++; $display("FAIL retry_saturate got=%0d exp=255", retry); end
        $display("test_timeout done retry=%0d", retry);
    endtask

    task automatic test_data();
        do_reset();
        lnk.i_Fifo_Full = 1'b0; lnk.i_Fifo_Empty = 1'b1;
        bring_up();
        total++; if (lnk.o_Tx_Ready !== 1'b1) begin bad++; $display("FAIL data_tx_ready got=%b exp=1", lnk.o_Tx_Ready); end
        lnk.i_Tx_Valid = 1'b1; lnk.i_Tx_Data = 8'h3C;
        tick();
        total++; if (lnk.o_Ser_Data !== 8'h3C || lnk.o_Ser_K !== 1'b0) begin bad++; $display("FAIL data_3c got=%h/%b exp=3c/0", lnk.o_Ser_Data, lnk.o_Ser_K); end
        lnk.i_Tx_Data = 8'h5A;
        tick();
        total++; if (lnk.o_Ser_Data !== 8'h5A || lnk.o_Ser_K !== 1'b0) begin bad++; $display("FAIL data_5a got=%h/%b exp=5a/0", lnk.o_Ser_Data, lnk.o_Ser_K); end
        lnk.i_Tx_Valid = 1'b0;
        tick();
        total++; if (lnk.o_Ser_Data !== 8'hBC || lnk.o_Ser_K !== 1'b1) begin bad++; $display("FAIL data_idle got=%h/%b exp=bc/1", lnk.o_Ser_Data, lnk.o_Ser_K); end
        total++; if (lnk.o_W_En !== 1'b1 || lnk.o_R_En !== 1'b0) begin bad++; $display("FAIL fifo_init got=%b/%b exp=1/0", lnk.o_W_En, lnk.o_R_En); end
        lnk.i_Fifo_Full = 1'b1;
        #1;
        total++; if (lnk.o_W_En !== 1'b1) begin bad++; $display("FAIL fifo_w_lag got=%b exp=1", lnk.o_W_En); end
        tick();
        total++; if (lnk.o_W_En !== 1'b0) begin bad++; $display("FAIL fifo_full got=%b exp=0", lnk.o_W_En); end
        lnk.i_Fifo_Empty = 1'b0;
        tick();
        total++; if (lnk.o_R_En !== 1'b1 || lnk.o_W_En !== 1'b0) begin bad++; $display("FAIL fifo_not_empty got=%b/%b exp=0/1", lnk.o_W_En, lnk.o_R_En); end
        lnk.i_Fifo_Full = 1'b0; lnk.i_Fifo_Empty = 1'b1;
        tick();
        total++; if (lnk.o_W_En !== 1'b1 || lnk.o_R_En !== 1'b0) begin bad++; $display("FAIL fifo_restore got=%b/%b exp=1/0", lnk.o_W_En, lnk.o_R_En); end
        $display("test_data done");
    endtask

    task automatic test_err_trip();
        do_reset();
        lnk.i_Fifo_Full = 1'b0; lnk.i_Fifo_Empty = 1'b0;
        bring_up();
        total++; if (lnk.o_W_En !== 1'b1 || lnk.o_R_En !== 1'b1) begin bad++; $display("FAIL err_pre_en got=%b/%b exp=1/1", lnk.o_W_En, lnk.o_R_En); end
        send_errors(ERR_MAX - 1);
        total++; if (state !== S_UP) begin bad++; $display("FAIL err_below_max got=%0d exp=%0d", state, S_UP); end
        send_errors(1);
        total++; if (state !== S_REC) begin bad++; $display("FAIL err_trip_state got=%0d exp=%0d", state, S_REC); end
        total++; if (link_up !== 1'b0 || lnk.o_Tx_Ready !== 1'b0) begin bad++; $display("FAIL err_trip_link got=%b/%b exp=0/0", link_up, lnk.o_Tx_Ready); end
        total++; if (lnk.o_W_En !== 1'b0 || lnk.o_R_En !== 1'b0) begin bad++; $display("FAIL err_trip_en got=%b/%b exp=0/0", lnk.o_W_En, lnk.o_R_En); end
        total++; if (retry !== 8'd1) begin bad++; $display("FAIL err_trip_retry got=%0d exp=1", retry); end
        lnk.i_Tx_Valid = 1'b1; lnk.i_Tx_Data = 8'h77;
        tick();
        lnk.i_Tx_Valid = 1'b0;
        total++; if (state !== S_IDLE) begin bad++; $display("FAIL err_back_idle got=%0d exp=%0d", state, S_IDLE); end
        total++; if (lnk.o_Ser_Data !== 8'hBC || lnk.o_Ser_K !== 1'b1) begin bad++; $display("FAIL exit_byte_dropped got=%h/%b exp=bc/1", lnk.o_Ser_Data, lnk.o_Ser_K); end
        lnk.i_Fifo_Empty = 1'b1;
        $display("test_err_trip done");
    endtask

    task automatic test_err_window();
        do_reset();
        bring_up();
        send_errors(ERR_MAX - 1);
        wait_cycles(ERR_WINDOW - ERR_MAX);
        send_errors(1);
        total++; if (state !== S_UP) begin bad++; $display("FAIL err_on_wrap got=%0d exp=%0d", state, S_UP); end
        send_errors(ERR_MAX - 2);
        total++; if (state !== S_UP) begin bad++; $display("FAIL err_new_window got=%0d exp=%0d", state, S_UP); end
        send_errors(1);
        total++; if (state !== S_REC) begin bad++; $display("FAIL err_new_window_trip got=%0d exp=%0d", state, S_REC); end
        $display("test_err_window done");
    endtask

    task automatic test_rst_mid();
        do_reset();
        for (int i = 0; i < 2; i++) begin
            wait_cycles(RST_HOLD + TRAIN_TIMEOUT);
            tick();
        end
        total++; if (state !== S_IDLE || retry !== 8'd2) begin bad++; $display("FAIL rst_mid_pre got=%0d/%0d exp=%0d/2", state, retry, S_IDLE); end
        bring_up();
        total++; if (state !== S_UP) begin bad++; $display("FAIL rst_mid_up got=%0d exp=%0d", state, S_UP); end
        lnk.i_Tx_Valid = 1'b1; lnk.i_Tx_Data = 8'h55;
        lnk.i_Fifo_Full = 1'b0; lnk.i_Fifo_Empty = 1'b0;
        lnk.i_Rx_Valid = 1'b1; lnk.i_Rx_Comma = 1'b1;
        rst = 1'b1;
        tick();
        total++; if (state !== S_IDLE || link_up !== 1'b0) begin bad++; $display("FAIL rst_mid_state got=%0d/%b exp=0/0", state, link_up); end
        total++; if (retry !== 8'd0) begin bad++; $display("FAIL rst_mid_retry got=%0d exp=0", retry); end
        total++; if (lnk.o_Ser_Data !== 8'hBC || lnk.o_Ser_K !== 1'b1 || lnk.o_Tx_Ready !== 1'b0) begin bad++; $display("FAIL rst_mid_tx got=%h/%b/%b exp=bc/1/0", lnk.o_Ser_Data, lnk.o_Ser_K, lnk.o_Tx_Ready); end
        total++; if (lnk.o_W_En !== 1'b0 || lnk.o_R_En !== 1'b0) begin bad++; $display("FAIL rst_mid_en got=%b/%b exp=0/0", lnk.o_W_En, lnk.o_R_En); end
        rst = 1'b0;
        lnk.i_Tx_Valid = 1'b0; lnk.i_Rx_Valid = 1'b0; lnk.i_Rx_Comma = 1'b0;
        $display("test_rst_mid done");
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        lnk.i_Tx_Data = 8'h00; lnk.i_Tx_Valid = 1'b0;
        lnk.i_Rx_Valid = 1'b0; lnk.i_Rx_Comma = 1'b0; lnk.i_Rx_Code_Err = 1'b0;
        lnk.i_Fifo_Full = 1'b0; lnk.i_Fifo_Empty = 1'b1;
        test_reset();
        test_lock();
        test_lock_clear();
        test_timeout();
        test_data();
        test_err_trip();
        test_err_window();
        test_rst_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Guard against a stalled run.
    initial begin
        #5_000_000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
